// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the pipelined MIPS core. It tracks in-flight
// destinations past ID and produces the stall, flush and EX forwarding selects.
module pipeline_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SEL_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_branch,
  input  logic              branch_taken,
  output logic              stall,
  output logic              pc_we,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              we;
    logic              is_load;
  } sb_entry_t;

  sb_entry_t         r_sb [DEPTH];
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_ex_rs_used;
  logic              r_ex_rt_used;
  logic              r_rst_d;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_mask;
  logic              w_hazard;
  logic              w_stall;
  logic              w_flush;
  logic              w_advance;
  logic [SEL_W-1:0]  w_fwd_a;
  logic [SEL_W-1:0]  w_fwd_b;
  sb_entry_t         w_id_entry;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic f_match(input sb_entry_t e, input logic [REG_AW-1:0] s,
                                   input logic used);
    return e.valid && e.we && (e.dst == s) && (s != '0) && used;
  endfunction

  // The WB entry is excluded from the search: the register file is write-first.
  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
      if (f_match(r_sb[k], id_rs, id_rs_used) || f_match(r_sb[k], id_rt, id_rt_used)) begin
        if ((FWD_EN == 0) || id_is_branch || (r_sb[k].is_load && (k < LOAD_STAGE))) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  // Outputs are held quiet during reset and the cycle after it.
  assign w_mask    = rst | r_rst_d;
  assign w_stall   = w_hazard & id_valid & ~w_mask;
  assign w_flush   = branch_taken & id_valid & ~w_stall & ~w_mask;
  assign w_advance = id_valid & ~w_stall;

  // Ascending search keeps the first hit, i.e. the youngest producer.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    if (FWD_EN != 0) begin
      for (int unsigned j = 1; j < DEPTH; j++) begin
        if (!(r_sb[j].is_load && (j <= LOAD_STAGE))) begin
          if ((w_fwd_a == '0) && f_match(r_sb[j], r_ex_rs, r_ex_rs_used)) begin
            w_fwd_a = SEL_W'(j);
          end
          if ((w_fwd_b == '0) && f_match(r_sb[j], r_ex_rt, r_ex_rt_used)) begin
            w_fwd_b = SEL_W'(j);
          end
        end
      end
    end
  end

  always_comb begin
    w_id_entry = '0;
    if (w_advance) begin
      w_id_entry.valid   = 1'b1;
      w_id_entry.dst     = id_dst;
      w_id_entry.we      = id_we;
      w_id_entry.is_load = id_is_load;
    end
  end

  // Scoreboard shift, EX source latches and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_sb[k] <= '0;
      end
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rs_used <= 1'b0;
      r_ex_rt_used <= 1'b0;
      r_rst_d      <= 1'b1;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_rst_d <= 1'b0;
      r_sb[0] <= w_id_entry;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
      if (w_advance) begin
        r_ex_rs      <= id_rs;
        r_ex_rt      <= id_rt;
        r_ex_rs_used <= id_rs_used;
        r_ex_rt_used <= id_rt_used;
      end else begin
        r_ex_rs      <= '0;
        r_ex_rt      <= '0;
        r_ex_rs_used <= 1'b0;
        r_ex_rt_used <= 1'b0;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall      = w_stall;
  assign pc_we      = ~w_stall;
  assign ifid_en    = ~w_stall;
  assign ifid_flush = w_flush;
  assign fwd_a      = w_mask ? '0 : w_fwd_a;
  assign fwd_b      = w_mask ? '0 : w_fwd_b;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  a_no_flush_in_stall: assert property (@(posedge clk) !(stall && ifid_flush));

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: three configurations share one ID stream, and
// expected outputs are queued as each cycle is driven and compared once it settles.
module tb_pipeline_hazard_unit;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_we, id_is_load, id_is_branch, branch_taken;
  logic [4:0] id_rs, id_rt, id_dst;

  logic        a_stall, a_pc_we, a_ifid_en, a_flush;
  logic [2:0]  a_fa, a_fb;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_stall, b_pc_we, b_ifid_en, b_flush;
  logic [2:0]  b_fa, b_fb;
  logic [15:0] b_scnt, b_fcnt;
  logic        c_stall, c_pc_we, c_ifid_en, c_flush;
  logic [2:0]  c_fa, c_fb;
  logic [1:0]  c_scnt, c_fcnt;

  pipeline_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(1), .FWD_EN(1), .CNT_W(16), .SEL_W(3)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .stall(a_stall), .pc_we(a_pc_we), .ifid_en(a_ifid_en), .ifid_flush(a_flush),
    .fwd_a(a_fa), .fwd_b(a_fb), .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  pipeline_hazard_unit #(.REG_AW(5), .DEPTH(4), .LOAD_STAGE(1), .FWD_EN(0), .CNT_W(16), .SEL_W(3)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .stall(b_stall), .pc_we(b_pc_we), .ifid_en(b_ifid_en), .ifid_flush(b_flush),
    .fwd_a(b_fa), .fwd_b(b_fb), .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  pipeline_hazard_unit #(.REG_AW(5), .DEPTH(6), .LOAD_STAGE(1), .FWD_EN(0), .CNT_W(2), .SEL_W(3)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .stall(c_stall), .pc_we(c_pc_we), .ifid_en(c_ifid_en), .ifid_flush(c_flush),
    .fwd_a(c_fa), .fwd_b(c_fb), .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

  typedef struct {
    logic v; logic [4:0] rs; logic [4:0] rt; logic ru; logic tu; logic [4:0] dst;
    logic we; logic ld; logic br; logic tk; logic st; logic fl; logic [2:0] fa; logic [2:0] fb;
  } row_t;

  typedef struct packed {
    logic st; logic pcwe; logic ifen; logic fl; logic [2:0] fa; logic [2:0] fb;
  } obs_t;

  obs_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic row_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ru, input logic tu, input logic [4:0] dst,
                              input logic we, input logic ld, input logic br, input logic tk,
                              input logic st, input logic fl, input logic [2:0] fa,
                              input logic [2:0] fb);
    row_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.ru = ru; r.tu = tu; r.dst = dst;
    r.we = we; r.ld = ld; r.br = br; r.tk = tk; r.st = st; r.fl = fl; r.fa = fa; r.fb = fb;
    return r;
  endfunction

  function automatic row_t idle_row();
    return mk(F, 5'd0, 5'd0, F, F, 5'd0, F, F, F, F, F, F, 3'd0, 3'd0);
  endfunction

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_dst = '0; id_we = 1'b0; id_is_load = 1'b0; id_is_branch = 1'b0; branch_taken = 1'b0;
  endtask

  // Drives one ID cycle and queues what the outputs must show in that cycle.
  task automatic drive_row(input row_t r);
    obs_t e;
    id_valid = r.v; id_rs = r.rs; id_rt = r.rt; id_rs_used = r.ru; id_rt_used = r.tu;
    id_dst = r.dst; id_we = r.we; id_is_load = r.ld; id_is_branch = r.br; branch_taken = r.tk;
    e.st = r.st; e.pcwe = ~r.st; e.ifen = ~r.st; e.fl = r.fl; e.fa = r.fa; e.fb = r.fb;
    q_exp.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    q_exp.delete();
  endtask

  task automatic test_reset();
    obs_t e, o;
    e = '0; e.pcwe = 1'b1; e.ifen = 1'b1;
    rst = 1'b1;
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rs_used = 1'b1; id_rt_used = 1'b1;
    id_dst = 5'd0; id_we = 1'b0; id_is_load = 1'b0; id_is_branch = 1'b1; branch_taken = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    o = {a_stall, a_pc_we, a_ifid_en, a_flush, a_fa, a_fb};
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", o, e); end
    n_checks++;
    if ({a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got a=%0d/%0d b=%0d/%0d c=%0d/%0d expected all 0",
               a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    o = {a_stall, a_pc_we, a_ifid_en, a_flush, a_fa, a_fb};
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL post_reset_quiet: got %b expected %b", o, e); end
    @(posedge clk); #1;
    @(negedge clk);
    e.fl = 1'b1;
    o = {a_stall, a_pc_we, a_ifid_en, a_flush, a_fa, a_fb};
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL taken_branch_after_reset: got %b expected %b", o, e); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_fwd_alu();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(T, 5'd1,  5'd2,  T, T, 5'd3,  T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd3,  5'd5,  T, T, 5'd4,  T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(F, 5'd0,  5'd0,  F, F, 5'd0,  F, F, F, F, F, F, 3'd1, 3'd0));
    rows.push_back(idle_row());
    rows.push_back(mk(T, 5'd1,  5'd2,  T, T, 5'd10, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(idle_row());
    rows.push_back(mk(T, 5'd10, 5'd10, T, T, 5'd11, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(F, 5'd0,  5'd0,  F, F, 5'd0,  F, F, F, F, F, F, 3'd2, 3'd2));
    rows.push_back(idle_row());
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = q_exp.pop_front();
      o = {a_stall, a_pc_we, a_ifid_en, a_flush, a_fa, a_fb};
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL fwd_alu cycle %0d: got %b expected %b", i, o, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_scnt !== 16'd0) begin n_fail++; $display("FAIL fwd_alu_stall_cnt: got %0d expected 0", a_scnt); end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(T, 5'd1, 5'd0, T, F, 5'd2, T, T, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd2, 5'd2, T, T, 5'd6, T, F, F, F, T, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd2, 5'd2, T, T, 5'd6, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(F, 5'd0, 5'd0, F, F, 5'd0, F, F, F, F, F, F, 3'd2, 3'd2));
    rows.push_back(idle_row());
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = q_exp.pop_front();
      o = {a_stall, a_pc_we, a_ifid_en, a_flush, a_fa, a_fb};
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL load_use cycle %0d: got %b expected %b", i, o, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_scnt !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected 1", a_scnt); end
  endtask

  task automatic test_branch();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(T, 5'd1, 5'd2, T, T, 5'd7, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd7, 5'd0, T, T, 5'd0, F, F, T, T, T, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd7, 5'd0, T, T, 5'd0, F, F, T, T, T, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd7, 5'd0, T, T, 5'd0, F, F, T, T, F, T, 3'd0, 3'd0));
    rows.push_back(idle_row());
    rows.push_back(mk(F, 5'd0, 5'd0, F, F, 5'd0, F, F, F, T, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd1, 5'd2, T, T, 5'd0, F, F, T, T, F, T, 3'd0, 3'd0));
    rows.push_back(idle_row());
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = q_exp.pop_front();
      o = {a_stall, a_pc_we, a_ifid_en, a_flush, a_fa, a_fb};
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL branch cycle %0d: got %b expected %b", i, o, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_scnt !== 16'd2) begin n_fail++; $display("FAIL branch_stall_cnt: got %0d expected 2", a_scnt); end
    n_checks++;
    if (a_fcnt !== 16'd2) begin n_fail++; $display("FAIL branch_flush_cnt: got %0d expected 2", a_fcnt); end
  endtask

  task automatic test_zero_and_youngest();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(T, 5'd1, 5'd0, T, F, 5'd0, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd0, 5'd0, T, T, 5'd5, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd0, 5'd0, T, T, 5'd0, F, F, T, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd1, 5'd2, T, T, 5'd8, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd1, 5'd2, T, T, 5'd8, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd8, 5'd8, T, T, 5'd9, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(F, 5'd0, 5'd0, F, F, 5'd0, F, F, F, F, F, F, 3'd1, 3'd1));
    rows.push_back(idle_row());
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = q_exp.pop_front();
      o = {a_stall, a_pc_we, a_ifid_en, a_flush, a_fa, a_fb};
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL zero_youngest cycle %0d: got %b expected %b", i, o, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_scnt !== 16'd0) begin n_fail++; $display("FAIL zero_youngest_stall_cnt: got %0d expected 0", a_scnt); end
  endtask

  task automatic test_interlock();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(T, 5'd1, 5'd2, T, T, 5'd9,  T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F, T, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F, T, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F, T, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(idle_row());
    rows.push_back(mk(T, 5'd1, 5'd2, T, T, 5'd9,  T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(mk(T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F, T, F, 3'd0, 3'd0));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = q_exp.pop_front();
      o = {b_stall, b_pc_we, b_ifid_en, b_flush, b_fa, b_fb};
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL interlock cycle %0d: got %b expected %b", i, o, e); end
      @(posedge clk); #1;
    end
    // Dependent instruction still in ID with its producer in entry 1; reset lands mid-stall.
    rst = 1'b1;
    @(negedge clk);
    e = '0; e.pcwe = 1'b1; e.ifen = 1'b1;
    o = {b_stall, b_pc_we, b_ifid_en, b_flush, b_fa, b_fb};
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL interlock_in_reset: got %b expected %b", o, e); end
    n_checks++;
    if (b_scnt !== 16'd4) begin n_fail++; $display("FAIL interlock_stall_cnt: got %0d expected 4", b_scnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    o = {b_stall, b_pc_we, b_ifid_en, b_flush, b_fa, b_fb};
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL interlock_after_reset: got %b expected %b", o, e); end
    n_checks++;
    if ({b_scnt, b_fcnt} !== 32'd0) begin
      n_fail++; $display("FAIL interlock_cnt_cleared: got %0d/%0d expected 0/0", b_scnt, b_fcnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    o = {b_stall, b_pc_we, b_ifid_en, b_flush, b_fa, b_fb};
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL interlock_tracking_dropped: got %b expected %b", o, e); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_saturation();
    row_t rows[$];
    obs_t e, o;
    logic [1:0] sc;
    do_reset();
    sc = 2'd0;
    rows.push_back(mk(T, 5'd1, 5'd2, T, T, 5'd9, T, F, F, F, F, F, 3'd0, 3'd0));
    for (int k = 0; k < 5; k++) begin
      rows.push_back(mk(T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F, T, F, 3'd0, 3'd0));
    end
    rows.push_back(mk(T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F, F, F, 3'd0, 3'd0));
    rows.push_back(idle_row());
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk);
      e = q_exp.pop_front();
      o = {c_stall, c_pc_we, c_ifid_en, c_flush, c_fa, c_fb};
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL saturate cycle %0d: got %b expected %b", i, o, e); end
      n_checks++;
      if (c_scnt !== sc) begin n_fail++; $display("FAIL saturate_cnt cycle %0d: got %0d expected %0d", i, c_scnt, sc); end
      if (e.st && (sc != 2'd3)) sc = sc + 2'd1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (c_scnt !== 2'd3) begin n_fail++; $display("FAIL saturate_final: got %0d expected 3", c_scnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_branch();
    test_zero_and_youngest();
    test_interlock();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS core.
- Tracks in-flight destination registers past ID in an internal scoreboard shift pipeline.
- Produces stall, flush and EX-stage forwarding selects, which drive the PC/latch enables and the Data_1/Data_2 forwarding muxes.
- Adds an interlock-only mode and stall/flush performance counters.

Parameters:
REG_AW, 5, register address width
DEPTH, 3, tracked stages after ID (entry 0=EX, 1=MEM, ..., DEPTH-1=WB); legal range 2..7
LOAD_STAGE, 1, entry index at whose end load data becomes forwardable; must be < DEPTH-1
FWD_EN, 1, 1 = forwarding mode; 0 = interlock-only mode (no forwarding)
CNT_W, 16, performance counter width
SEL_W, 3, forwarding select width; must satisfy 2^SEL_W > DEPTH-1

Ports:
clk  in  1  clock
rst  in  1  reset
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  REG_AW  ID source register addresses
id_rs_used, id_rt_used  in  1  source is actually read
id_dst  in  REG_AW  ID destination (after RegDst selection)
id_we  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is lw
id_is_branch  in  1  ID instruction compares registers in ID
branch_taken  in  1  ID branch resolved taken
stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
pc_we, ifid_en  out  1  both equal ~stall
ifid_flush  out  1  clear IF/ID
fwd_a, fwd_b  out  SEL_W  EX operand select: 0 = register file, j = result of entry j
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: clk and rst only. rst is synchronous, active-high.
  - Reset clears every scoreboard entry (valid, dst, we, load = 0), the EX source latches and both counters.
  - All outputs read 0 during reset and in the cycle after, except pc_we = ifid_en = 1.
  - An assertion mid-operation discards all in-flight tracking on the same edge.
- Scoreboard:
  - Each entry holds {valid, dst, we, is_load}.
  - Every clock edge: entry k+1 <= entry k. Entry 0 <= ID instruction if id_valid & ~stall, else a bubble (valid = 0). The oldest entry is discarded.
  - EX source latches (ex_rs, ex_rt and their used bits) load from ID on the same condition, else clear.
- Match definition for source s against entry k: valid & we & (dst == s) & (s != 0) & s_used. Register 0 never matches.
- Stall (combinational from state plus ID inputs), FWD_EN = 1. Stall if any used source matches:
  - a load entry with k < LOAD_STAGE (load-use);
  - or, when id_is_branch, any entry with k <= DEPTH-2. ID-stage compares get no forwarding.
- Stall, FWD_EN = 0: stall on any match with k <= DEPTH-2.
- The entry DEPTH-1 (WB) producer is never a hazard: the register file is write-first within a cycle.
- Forwarding (FWD_EN = 1), per EX source:
  - Select the smallest j in 1..DEPTH-1 whose entry matches; that is the youngest producer.
  - Entries that are loads with j <= LOAD_STAGE are excluded; the stall rule guarantees they never occur.
  - No match gives 0. With FWD_EN = 0, fwd_a = fwd_b = 0 always.
- Flush: ifid_flush = branch_taken & id_valid & ~stall.
  - Stall has priority: a taken branch during a stall is ignored and re-evaluated when ID re-presents.
  - ifid_flush never asserts together with stall.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with ifid_flush = 1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Latency: stall, flush and fwd are combinational within the cycle; the scoreboard updates on the next edge.
- An arbitrary-length stall holds ID. The scoreboard keeps draining, so the stall self-clears once the producer advances.

Test Plan:
- add $3 in EX-entry, then sub $4,$3,$5 enters EX next cycle -> fwd_a=1, stall=0, stall_cnt stays 0.
- lw $2 followed directly by add $6,$2,$2 -> exactly 1 stall cycle (pc_we=0), then fwd_a=fwd_b=2 in EX, stall_cnt=1.
- beq $7,$0 directly after add $7 (DEPTH=3) -> 2 stall cycles. Then branch_taken=1 gives ifid_flush=1 for 1 cycle, flush_cnt=1.
- Writes to $0 followed by reads of $0 -> no stall, fwd=0. Back-to-back writes of $8 in entries 1 and 2 -> fwd selects 1, the youngest producer.
- FWD_EN=0, DEPTH=4: add $9 then dependent instruction -> 3 stall cycles, fwd always 0. Assert rst mid-stall -> stall=0 next cycle, counters 0.
- CNT_W=2 with 5 consecutive stall cycles -> stall_cnt saturates at 3.
